ioctl_cart_loader: RTL and testbench

Parametrised download engine between the HPS `ioctl_*` stream and the core's BIOS and cart memories. It classifies each download by `ioctl_index` and, for cart images, parses the header (magic, flags, controller types, region, save type). It strips the header from the write address, issues handshaked single-byte memory writes with `ioctl_wait` back-pressure, and reports the final payload size. It replaces the ad-hoc header and size logic in the top level; it sits between `hps_io` and the `dpram_dc` or SDRAM cart store.

---
 rtl/ioctl_cart_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_ioctl_cart_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_cart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ioctl_cart_loader
//  Description : Download engine between the HPS ioctl byte stream and the
//                core's BIOS / cart memories.
//                - Classifies each download as BIOS or cart from ioctl_index.
//                - Parses the cart header (magic, flags, controllers, region,
//                  save type).
//                - Strips the header from the cart write address.
//                - Issues one handshaked byte write per strobe, holding
//                  ioctl_wait high until the memory acknowledges.
//                - Reports the payload size when a cart download ends.
//  Ports       : clk_sys, reset_n (async, active-low)
//                ioctl_*          host download stream in, ioctl_wait out
//                mem_wr/tgt/addr/data, mem_ack   memory write handshake
//                hdr_valid, cart_flags, joy0_type, joy1_type, cart_region,
//                cart_save        parsed header fields
//                cart_size, overflow, load_done, initial_pause  status
//  Revision    : 1.0 - initial release
// ============================================================================
module ioctl_cart_loader #(
    parameter int          ADDR_W      = 18,
    parameter int          BIOS_ADDR_W = 12,
    parameter int          HDR_LEN     = 128,
    parameter logic [39:0] MAGIC       = 40'h41_54_41_52_49, // "ATARI"
    parameter logic [7:0]  BIOS_INDEX  = 8'd0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic              mem_wr,
    output logic              mem_tgt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ack,
    output logic              hdr_valid,
    output logic [15:0]       cart_flags,
    output logic [7:0]        joy0_type,
    output logic [7:0]        joy1_type,
    output logic [7:0]        cart_region,
    output logic [7:0]        cart_save,
    output logic [31:0]       cart_size,
    output logic              overflow,
    output logic              load_done,
    output logic              initial_pause
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [31:0] c_HDR_LEN = 32'(HDR_LEN);

    logic [1:0]        r_state;
    logic              r_dl_prev;
    logic              r_tgt;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_data;
    logic              r_hdr_valid;
    logic [31:0]       r_magic;      // header bytes 1..4, byte 1 in the MSBs
    logic [15:0]       r_flags;
    logic [7:0]        r_joy0;
    logic [7:0]        r_joy1;
    logic [7:0]        r_region;
    logic [7:0]        r_save;
    logic [31:0]       r_cart_size;
    logic              r_overflow;
    logic              r_load_done;
    logic              r_initial_pause;
    logic [24:0]       r_last_addr;
    logic              r_got_byte;   // at least one byte captured this download

    logic [31:0]       w_addr_ext;
    logic [31:0]       w_cart_addr;
    logic              w_cart_ovf;
    logic [ADDR_W-1:0] w_bios_addr;
    logic              w_is_cart;

    assign w_addr_ext  = {7'd0, ioctl_addr};
    // Header stripping only kicks in once the magic has been seen, so the
    // header bytes themselves land raw at the bottom of cart memory and are
    // later overwritten by the payload.
    assign w_cart_addr = (r_hdr_valid && (w_addr_ext >= c_HDR_LEN)) ?
                         (w_addr_ext - c_HDR_LEN) : w_addr_ext;
    assign w_cart_ovf  = (w_cart_addr >> ADDR_W) != 32'd0;
    assign w_bios_addr = ADDR_W'(ioctl_addr[BIOS_ADDR_W-1:0]);
    assign w_is_cart   = (ioctl_index != BIOS_INDEX);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_dl_prev       <= 1'b0;
            r_tgt           <= 1'b0;
            r_mem_wr        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_data      <= 8'd0;
            r_hdr_valid     <= 1'b0;
            r_magic         <= 32'd0;
            r_flags         <= 16'd0;
            r_joy0          <= 8'd0;
            r_joy1          <= 8'd0;
            r_region        <= 8'd0;
            r_save          <= 8'd0;
            r_cart_size     <= 32'd0;
            r_overflow      <= 1'b0;
            r_load_done     <= 1'b0;
            r_initial_pause <= 1'b1;
            r_last_addr     <= 25'd0;
            r_got_byte      <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_dl_prev   <= ioctl_download;

            case (r_state)
                S_IDLE: begin
                    if (ioctl_download && !r_dl_prev) begin
                        r_tgt      <= w_is_cart;
                        r_got_byte <= 1'b0;
                        r_state    <= S_LOAD;
                        if (w_is_cart) begin
                            r_hdr_valid <= 1'b0;
                            r_overflow  <= 1'b0;
                            r_magic     <= 32'd0;
                            r_flags     <= 16'd0;
                            r_joy0      <= 8'd0;
                            r_joy1      <= 8'd0;
                            r_region    <= 8'd0;
                            r_save      <= 8'd0;
                        end
                    end
                end

                S_LOAD: begin
                    if (!ioctl_download) begin
                        r_state <= S_FINISH;
                    end else if (ioctl_wr) begin
                        r_last_addr <= ioctl_addr;
                        r_got_byte  <= 1'b1;
                        if (r_tgt) begin
                            // Header fields track their byte positions whether
                            // or not the magic matches; bytes 49..52 are unused.
                            case (ioctl_addr)
                                25'd1:  r_magic[31:24] <= ioctl_dout;
                                25'd2:  r_magic[23:16] <= ioctl_dout;
                                25'd3:  r_magic[15:8]  <= ioctl_dout;
                                25'd4:  r_magic[7:0]   <= ioctl_dout;
                                25'd5:  r_hdr_valid    <= ({r_magic, ioctl_dout} == MAGIC);
                                25'd53: r_flags[15:8]  <= ioctl_dout;
                                25'd54: r_flags[7:0]   <= ioctl_dout;
                                25'd55: r_joy0         <= ioctl_dout;
                                25'd56: r_joy1         <= ioctl_dout;
                                25'd57: r_region       <= ioctl_dout;
                                25'd58: r_save         <= ioctl_dout;
                                default: ;
                            endcase
                            if (w_cart_ovf) begin
                                // Out-of-range byte: flag it and drop it
                                // without stalling the host.
                                r_overflow <= 1'b1;
                            end else begin
                                r_mem_addr <= w_cart_addr[ADDR_W-1:0];
                                r_mem_data <= ioctl_dout;
                                r_mem_wr   <= 1'b1;
                                r_state    <= S_WRITE;
                            end
                        end else begin
                            r_mem_addr <= w_bios_addr;
                            r_mem_data <= ioctl_dout;
                            r_mem_wr   <= 1'b1;
                            r_state    <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    // Strobes arriving here are host protocol errors and are
                    // deliberately not looked at.
                    if (mem_ack) begin
                        r_mem_wr <= 1'b0;
                        r_state  <= ioctl_download ? S_LOAD : S_FINISH;
                    end
                end

                S_FINISH: begin
                    r_load_done <= 1'b1;
                    if (r_tgt) begin
                        if (r_got_byte) begin
                            r_cart_size <= {7'd0, r_last_addr} + 32'd1 -
                                           (r_hdr_valid ? c_HDR_LEN : 32'd0);
                        end else begin
                            r_cart_size <= 32'd0;
                        end
                        r_initial_pause <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The write request and the host stall are the same condition.
    assign mem_wr        = r_mem_wr;
    assign ioctl_wait    = r_mem_wr;
    assign mem_tgt       = r_tgt;
    assign mem_addr      = r_mem_addr;
    assign mem_data      = r_mem_data;
    assign hdr_valid     = r_hdr_valid;
    assign cart_flags    = r_flags;
    assign joy0_type     = r_joy0;
    assign joy1_type     = r_joy1;
    assign cart_region   = r_region;
    assign cart_save     = r_save;
    assign cart_size     = r_cart_size;
    assign overflow      = r_overflow;
    assign load_done     = r_load_done;
    assign initial_pause = r_initial_pause;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_cart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ioctl_cart_loader
//  Description : Self-checking bench for ioctl_cart_loader. DUT a uses the
//                default 18-bit cart space, DUT b a 10-bit cart space for the
//                capacity-overflow case; both see the same host stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_cart_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, dl, wr;
    logic [24:0] addr;
    logic [7:0]  dout, idx;
    logic        ack_a, ack_b;

    logic        wait_a, wr_a, tgt_a, hv_a, ovf_a, done_a, pause_a;
    logic [17:0] maddr_a;
    logic [7:0]  mdata_a, j0_a, j1_a, reg_a, sav_a;
    logic [15:0] flags_a;
    logic [31:0] size_a;

    logic        wait_b, wr_b, tgt_b, hv_b, ovf_b, done_b, pause_b;
    logic [9:0]  maddr_b;
    logic [7:0]  mdata_b, j0_b, j1_b, reg_b, sav_b;
    logic [15:0] flags_b;
    logic [31:0] size_b;

    ioctl_cart_loader u_dut_a (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(idx),
        .ioctl_wait(wait_a), .mem_wr(wr_a), .mem_tgt(tgt_a), .mem_addr(maddr_a),
        .mem_data(mdata_a), .mem_ack(ack_a), .hdr_valid(hv_a),
        .cart_flags(flags_a), .joy0_type(j0_a), .joy1_type(j1_a),
        .cart_region(reg_a), .cart_save(sav_a), .cart_size(size_a),
        .overflow(ovf_a), .load_done(done_a), .initial_pause(pause_a)
    );

    ioctl_cart_loader #(.ADDR_W(10)) u_dut_b (
        .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl), .ioctl_wr(wr),
        .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_index(idx),
        .ioctl_wait(wait_b), .mem_wr(wr_b), .mem_tgt(tgt_b), .mem_addr(maddr_b),
        .mem_data(mdata_b), .mem_ack(ack_b), .hdr_valid(hv_b),
        .cart_flags(flags_b), .joy0_type(j0_b), .joy1_type(j1_b),
        .cart_region(reg_b), .cart_save(sav_b), .cart_size(size_b),
        .overflow(ovf_b), .load_done(done_b), .initial_pause(pause_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responders: ack after ack_lat cycles of mem_wr
    int ack_lat = 1;
    initial begin
        int ca, cb;
        ca = 0; cb = 0; ack_a = 1'b0; ack_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wr_a) begin ca++; ack_a = (ca >= ack_lat); end
            else begin ca = 0; ack_a = 1'b0; end
            if (wr_b) begin cb++; ack_b = (cb >= ack_lat); end
            else begin cb = 0; ack_b = 1'b0; end
        end
    end

    // ---------------- monitors: accepted writes, load_done pulses, stability
    int          wcnt_a = 0, wcnt_b = 0, done_cnt = 0, instab = 0;
    logic [17:0] la_a;
    logic [9:0]  la_b;
    logic [7:0]  ld_a, ld_b;
    logic        lt_a, lt_b;
    initial begin
        logic        held;
        logic [17:0] h_addr;
        logic [7:0]  h_data;
        logic        h_tgt;
        held = 1'b0; h_addr = '0; h_data = '0; h_tgt = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_a && ack_a) begin wcnt_a++; la_a = maddr_a; ld_a = mdata_a; lt_a = tgt_a; end
            if (wr_b && ack_b) begin wcnt_b++; la_b = maddr_b; ld_b = mdata_b; lt_b = tgt_b; end
            if (done_a) done_cnt++;
            if (wr_a) begin
                if (held) begin
                    if (maddr_a !== h_addr || mdata_a !== h_data || tgt_a !== h_tgt) instab++;
                end else begin
                    held = 1'b1; h_addr = maddr_a; h_data = mdata_a; h_tgt = tgt_a;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    // ---------------- host byte strobe; returns ioctl_wait high-cycles per DUT
    task automatic send_byte(input int a, input int d, output int wc_a, output int wc_b);
        int guard;
        addr = 25'(a); dout = 8'(d); wr = 1'b1;
        tick;
        wr = 1'b0;
        wc_a = 0; wc_b = 0; guard = 0;
        while ((wait_a || wait_b) && guard < 200) begin
            if (wait_a) wc_a++;
            if (wait_b) wc_b++;
            tick;
            guard++;
        end
        if (guard >= 200) begin
            checks++; failures++;
            $display("FAIL wait_timeout: ioctl_wait still high after %0d cycles, required low", guard);
        end
        tick;
    endtask

    // ---------------- vector table
    // op 0: start download (a = index)
    // op 1: byte (a, d) on DUT dut; e_wr = write expected, e_addr = mem_addr
    // op 2: end download; expect e_size, e_hv, e_pause, e_ovf on DUT dut
    typedef struct {
        int op; int dut; int a; int d; int e_wr; int e_addr;
        int e_size; int e_hv; int e_pause; int e_ovf;
    } vec_t;
    vec_t vq[$];

    function automatic void vs(input int index);
        vq.push_back('{0, 0, index, 0, 0, 0, 0, 0, 0, 0});
    endfunction
    function automatic void vb(input int dsel, input int a, input int d, input int ewr, input int ea);
        vq.push_back('{1, dsel, a, d, ewr, ea, 0, 0, 0, 0});
    endfunction
    function automatic void ve(input int dsel, input int sz, input int hv, input int pz, input int ov);
        vq.push_back('{2, dsel, 0, 0, 0, 0, sz, hv, pz, ov});
    endfunction

    logic cur_tgt;

    task automatic run_range(input int lo, input int hi);
        int ca, cb, wca, wcb;
        for (int i = lo; i < hi; i++) begin
            case (vq[i].op)
                0: begin
                    idx = 8'(vq[i].a); dl = 1'b1;
                    cur_tgt = (vq[i].a != 0);
                    tick; tick;
                    if (cur_tgt) begin
                        chk($sformatf("v%0d_start_hv", i), hv_a, 0);
                        chk($sformatf("v%0d_start_flags", i), flags_a, 0);
                        chk($sformatf("v%0d_start_ovf_b", i), ovf_b, 0);
                    end
                end
                1: begin
                    ca = wcnt_a; cb = wcnt_b;
                    send_byte(vq[i].a, vq[i].d, wca, wcb);
                    if (vq[i].dut == 0) begin
                        chk($sformatf("v%0d_wr_cnt", i), wcnt_a - ca, vq[i].e_wr);
                        chk($sformatf("v%0d_wait_cyc", i), wca, vq[i].e_wr);
                        if (vq[i].e_wr != 0) begin
                            chk($sformatf("v%0d_addr", i), la_a, vq[i].e_addr);
                            chk($sformatf("v%0d_data", i), ld_a, vq[i].d);
                            chk($sformatf("v%0d_tgt", i), lt_a, cur_tgt);
                        end
                    end else begin
                        chk($sformatf("v%0d_wr_cnt_b", i), wcnt_b - cb, vq[i].e_wr);
                        chk($sformatf("v%0d_wait_cyc_b", i), wcb, vq[i].e_wr);
                        if (vq[i].e_wr != 0) begin
                            chk($sformatf("v%0d_addr_b", i), la_b, vq[i].e_addr);
                            chk($sformatf("v%0d_data_b", i), ld_b, vq[i].d);
                            chk($sformatf("v%0d_tgt_b", i), lt_b, cur_tgt);
                        end
                    end
                end
                default: begin
                    dl = 1'b0;
                    tick;
                    chk($sformatf("v%0d_done_early", i), done_a, 0);
                    tick;
                    chk($sformatf("v%0d_done", i), done_a, 1);
                    if (vq[i].dut == 0) begin
                        chk($sformatf("v%0d_size", i), size_a, vq[i].e_size);
                        chk($sformatf("v%0d_hv", i), hv_a, vq[i].e_hv);
                        chk($sformatf("v%0d_pause", i), pause_a, vq[i].e_pause);
                        chk($sformatf("v%0d_ovf", i), ovf_a, vq[i].e_ovf);
                    end else begin
                        chk($sformatf("v%0d_size_b", i), size_b, vq[i].e_size);
                        chk($sformatf("v%0d_hv_b", i), hv_b, vq[i].e_hv);
                        chk($sformatf("v%0d_pause_b", i), pause_b, vq[i].e_pause);
                        chk($sformatf("v%0d_ovf_b", i), ovf_b, vq[i].e_ovf);
                    end
                    tick;
                    chk($sformatf("v%0d_done_pulse", i), done_a, 0);
                end
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n1, wca, wcb, dc;

        // Headered cart: "ATARI" at 1..5, flags 0x1234, 16512 bytes total.
        vs(1);
        vb(0, 0, 8'h01, 1, 0);
        vb(0, 1, 8'h41, 1, 1); vb(0, 2, 8'h54, 1, 2); vb(0, 3, 8'h41, 1, 3);
        vb(0, 4, 8'h52, 1, 4); vb(0, 5, 8'h49, 1, 5);
        vb(0, 53, 8'h12, 1, 53); vb(0, 54, 8'h34, 1, 54); vb(0, 55, 8'h11, 1, 55);
        vb(0, 56, 8'h22, 1, 56); vb(0, 57, 8'h33, 1, 57); vb(0, 58, 8'h44, 1, 58);
        vb(0, 127, 8'h77, 1, 127);
        vb(0, 128, 8'hA5, 1, 0); vb(0, 129, 8'h3C, 1, 1);
        vb(0, 16511, 8'h5A, 1, 16383);
        ve(0, 16384, 1, 0, 0);
        n1 = vq.size();
        // BIOS: raw truncated addresses, cart status left alone.
        vs(0);
        vb(0, 0, 8'h01, 1, 0); vb(0, 1, 8'h02, 1, 1);
        vb(0, 200, 8'h03, 1, 200); vb(0, 4095, 8'hFF, 1, 4095);
        ve(0, 16384, 1, 0, 0);
        // Headerless cart of 32768 bytes.
        vs(2);
        for (int k = 0; k < 6; k++) vb(0, k, 8'h10 + k, 1, k);
        vb(0, 200, 8'hC8, 1, 200); vb(0, 32767, 8'hEE, 1, 32767);
        ve(0, 32768, 0, 0, 0);
        // Overflow on the 10-bit DUT: 2000-byte headerless cart.
        vs(3);
        vb(1, 0, 8'h01, 1, 0); vb(1, 1023, 8'h02, 1, 1023);
        vb(1, 1024, 8'h03, 0, 0); vb(1, 1999, 8'h04, 0, 0);
        ve(1, 2000, 0, 0, 1);
        // Empty cart: clears overflow, size 0.
        vs(4);
        ve(1, 0, 0, 0, 0);

        reset_n = 1'b0; dl = 1'b0; wr = 1'b0; addr = '0; dout = '0; idx = '0;
        tick; tick; tick;
        reset_n = 1'b1;
        tick;
        chk("rst_wait", wait_a, 0);   chk("rst_mem_wr", wr_a, 0);
        chk("rst_tgt", tgt_a, 0);     chk("rst_addr", maddr_a, 0);
        chk("rst_data", mdata_a, 0);  chk("rst_hv", hv_a, 0);
        chk("rst_flags", flags_a, 0); chk("rst_joy0", j0_a, 0);
        chk("rst_size", size_a, 0);   chk("rst_ovf", ovf_a, 0);
        chk("rst_done", done_a, 0);   chk("rst_pause", pause_a, 1);

        run_range(0, n1);
        chk("hdr_flags", flags_a, 16'h1234);
        chk("hdr_joy0", j0_a, 8'h11);
        chk("hdr_joy1", j1_a, 8'h22);
        chk("hdr_region", reg_a, 8'h33);
        chk("hdr_save", sav_a, 8'h44);
        run_range(n1, vq.size());

        // Ack stretching: six cycles of mem_wr/ioctl_wait per byte.
        ack_lat = 6;
        idx = 8'd1; dl = 1'b1; cur_tgt = 1'b1;
        tick; tick;
        dc = instab;
        send_byte(0, 8'h9A, wca, wcb);
        chk("stretch_wait0", wca, 6);
        send_byte(7, 8'h6B, wca, wcb);
        chk("stretch_wait1", wca, 6);
        chk("stretch_addr", la_a, 7);
        chk("stretch_data", ld_a, 8'h6B);
        chk("stretch_stable", instab - dc, 0);
        dl = 1'b0;
        tick; tick; tick;
        chk("stretch_pause", pause_a, 0);

        // Reset while a write is pending.
        ack_lat = 50;
        idx = 8'd5; dl = 1'b1;
        tick; tick;
        addr = 25'd10; dout = 8'h55; wr = 1'b1;
        tick;
        wr = 1'b0;
        chk("abort_wr_before", wr_a, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_wr", wr_a, 0);
        chk("abort_wait", wait_a, 0);
        chk("abort_pause", pause_a, 1);
        dl = 1'b0;
        dc = done_cnt;
        tick; tick;
        reset_n = 1'b1;
        repeat (5) tick;
        chk("abort_no_done", done_cnt - dc, 0);
        chk("abort_pause_hold", pause_a, 1);
        ack_lat = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
